// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch
// Operand-fetch stage that sits between issue and execute and drives a
// synchronous-read 2R1W register-file SRAM.
//
// An instruction (rs1, rs2, tag) is accepted over a valid/ready handshake.
// Its operands are presented to execute one cycle later. Write-back
// forwarding covers three cases: a write in the accept cycle, a write
// during a stall, and a write in the current cycle. As a result, operands
// are never stale, even while execute holds the stage.
//
// Optional build macro: REGFILE_OPERAND_FETCH_ZERO_REG_EN
//   When defined, register index 0 is hardwired to zero. Reads of index 0
//   return 0, and write-backs to index 0 neither forward nor reach the SRAM.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               kill the in-flight and held instruction
//   in_valid/in_ready   issue handshake; in_rs1, in_rs2, in_tag payload
//   out_valid/out_ready execute handshake; out_rs1_data, out_rs2_data, out_tag
//   wb_we/waddr/wdata   write-back port
//   sram_raddr/raddr2   SRAM read addresses (driven combinationally from in_rs*)
//   sram_rdata/rdata2   SRAM read data, one cycle after the address
//   sram_we/waddr/wdata SRAM write port (driven from the write-back port)

module regfile_operand_fetch #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [TAG_WIDTH-1:0]  in_tag,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs1_data,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [TAG_WIDTH-1:0]  out_tag,

    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,

    output logic [ADDR_WIDTH-1:0] sram_raddr,
    output logic [ADDR_WIDTH-1:0] sram_raddr2,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata2,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [DATA_WIDTH-1:0] sram_wdata
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  fresh;      // first cycle after accept: SRAM data is live
    logic                  byp1;       // accept-cycle write-back hit rs1
    logic                  byp2;       // accept-cycle write-back hit rs2
    logic [ADDR_WIDTH-1:0] rs1_q;      // source indices of the presented instruction
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] hold1;      // bypass / holding register, operand 1
    logic [DATA_WIDTH-1:0] hold2;      // bypass / holding register, operand 2

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  wb_eff;     // write-back that actually changes state
    logic                  accept;
    logic                  out_xfer;
    logic                  in_hit1;    // write-back hits the incoming source indices
    logic                  in_hit2;
    logic                  cur_hit1;   // write-back hits the presented source indices
    logic                  cur_hit2;
    logic [DATA_WIDTH-1:0] src1;       // operand before current-cycle forwarding
    logic [DATA_WIDTH-1:0] src2;

    // Write-back qualification. With a hardwired zero register, writes to
    // index 0 are dropped entirely.
`ifdef REGFILE_OPERAND_FETCH_ZERO_REG_EN
    assign wb_eff = wb_we && (wb_waddr != '0);
`else
    assign wb_eff = wb_we;
`endif

    // SRAM write and read address paths are pure wiring.
    assign sram_we     = wb_eff;
    assign sram_waddr  = wb_waddr;
    assign sram_wdata  = wb_wdata;
    assign sram_raddr  = in_rs1;
    assign sram_raddr2 = in_rs2;

    // Handshakes. Flush does not affect in_ready; it only discards the accept.
    assign in_ready = !out_valid || out_ready;
    assign out_xfer = out_valid && out_ready;
    assign accept   = in_valid && in_ready && !flush;

    assign in_hit1  = wb_eff && (wb_waddr == in_rs1);
    assign in_hit2  = wb_eff && (wb_waddr == in_rs2);
    assign cur_hit1 = wb_eff && (wb_waddr == rs1_q);
    assign cur_hit2 = wb_eff && (wb_waddr == rs2_q);

    // Operand select. Priority: current write-back > bypass/holding > SRAM.
    // SRAM data is only meaningful in the fresh cycle. After that, the
    // holding register carries the resolved value.
    always_comb begin
        src1         = hold1;
        src2         = hold2;
        out_rs1_data = '0;
        out_rs2_data = '0;

        if (fresh && !byp1) begin
            src1 = sram_rdata;
        end
        if (fresh && !byp2) begin
            src2 = sram_rdata2;
        end

        out_rs1_data = cur_hit1 ? wb_wdata : src1;
        out_rs2_data = cur_hit2 ? wb_wdata : src2;

`ifdef REGFILE_OPERAND_FETCH_ZERO_REG_EN
        if (rs1_q == '0) begin
            out_rs1_data = '0;
        end
        if (rs2_q == '0) begin
            out_rs2_data = '0;
        end
`endif
    end

    // Pipeline register. Accept wins over a same-cycle transfer, which gives
    // one instruction per cycle. While stalled, the resolved operands
    // (including any current write-back) are folded into the holding
    // registers every cycle. This both captures the fresh SRAM data and
    // tracks later writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            fresh     <= 1'b0;
            byp1      <= 1'b0;
            byp2      <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            hold1     <= '0;
            hold2     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            fresh     <= 1'b0;
            byp1      <= 1'b0;
            byp2      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_tag   <= in_tag;
            fresh     <= 1'b1;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            // The SRAM returns old data on read-during-write, so the
            // write-back value captured here replaces it next cycle.
            byp1      <= in_hit1;
            byp2      <= in_hit2;
            if (in_hit1) begin
                hold1 <= wb_wdata;
            end
            if (in_hit2) begin
                hold2 <= wb_wdata;
            end
        end else if (out_xfer) begin
            out_valid <= 1'b0;
            fresh     <= 1'b0;
            byp1      <= 1'b0;
            byp2      <= 1'b0;
        end else if (out_valid) begin
            fresh     <= 1'b0;
            byp1      <= 1'b0;
            byp2      <= 1'b0;
            hold1     <= out_rs1_data;
            hold2     <= out_rs2_data;
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Self-checking bench for regfile_operand_fetch.
// The bench contains a behavioural SRAM. Expected values come from an
// architectural register-file model: a presented operand must always equal
// the architectural value of its register, including any write-back in the
// current cycle.

module tb_regfile_operand_fetch;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 8;
    localparam int unsigned NREG = 32;

`ifdef REGFILE_OPERAND_FETCH_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_rs1_data;
    logic [DW-1:0] out_rs2_data;
    logic [TW-1:0] out_tag;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic [AW-1:0] sram_raddr;
    logic [AW-1:0] sram_raddr2;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] sram_rdata2;
    logic          sram_we;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;

    regfile_operand_fetch #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_tag(out_tag),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .sram_raddr(sram_raddr), .sram_raddr2(sram_raddr2),
        .sram_rdata(sram_rdata), .sram_rdata2(sram_rdata2),
        .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous-read SRAM; read-during-write returns old data.
    logic [DW-1:0] mem [NREG];
    always @(posedge clk) begin
        if (sram_we) mem[sram_waddr] <= sram_wdata;
        sram_rdata  <= mem[sram_raddr];
        sram_rdata2 <= mem[sram_raddr2];
    end

    // Reference model state.
    logic [DW-1:0] arch [NREG];
    logic          exp_valid;
    logic [AW-1:0] exp_rs1;
    logic [AW-1:0] exp_rs2;
    logic [TW-1:0] exp_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic wb_counts(input logic we, input logic [AW-1:0] wa);
        return we && !(ZERO_REG && wa == '0);
    endfunction

    // Architectural value of a register as seen in the current cycle.
    function automatic logic [DW-1:0] ref_op(input logic [AW-1:0] rs);
        if (ZERO_REG && rs == '0) return '0;
        if (wb_counts(wb_we, wb_waddr) && wb_waddr == rs) return wb_wdata;
        return arch[rs];
    endfunction

    task automatic set_in(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [TW-1:0] tg, input logic ordy, input logic fl);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_tag = tg; out_ready = ordy; flush = fl;
    endtask

    task automatic set_wb(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wb_we = we; wb_waddr = wa; wb_wdata = wd;
    endtask

    // One clock: check all outputs mid-cycle against the model, advance the model, step.
    task automatic cyc();
        logic acc;
        @(negedge clk);
        chk("in_ready", DW'(in_ready), DW'(!exp_valid || out_ready));
        chk("out_valid", DW'(out_valid), DW'(exp_valid));
        chk("sram_raddr", DW'(sram_raddr), DW'(in_rs1));
        chk("sram_raddr2", DW'(sram_raddr2), DW'(in_rs2));
        chk("sram_we", DW'(sram_we), DW'(wb_counts(wb_we, wb_waddr)));
        if (wb_we) begin
            chk("sram_waddr", DW'(sram_waddr), DW'(wb_waddr));
            chk("sram_wdata", sram_wdata, wb_wdata);
        end
        if (exp_valid) begin
            chk("out_tag", DW'(out_tag), DW'(exp_tag));
            chk("out_rs1_data", out_rs1_data, ref_op(exp_rs1));
            chk("out_rs2_data", out_rs2_data, ref_op(exp_rs2));
        end
        acc = in_valid && (!exp_valid || out_ready) && !flush;
        if (flush) exp_valid = 1'b0;
        else if (acc) begin
            exp_valid = 1'b1; exp_rs1 = in_rs1; exp_rs2 = in_rs2; exp_tag = in_tag;
        end else if (exp_valid && out_ready) exp_valid = 1'b0;
        if (wb_counts(wb_we, wb_waddr)) arch[wb_waddr] = wb_wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_valid = 1'b0; exp_rs1 = '0; exp_rs2 = '0; exp_tag = '0;
        for (int i = 0; i < int'(NREG); i++) arch[i] = '0;
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0);
        set_wb(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", DW'(out_valid), DW'(0));
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", DW'(in_ready), DW'(1));
        chk("reset out_tag", DW'(out_tag), DW'(0));

        // Preload every register through the write-back port.
        for (int i = 0; i < int'(NREG); i++) begin
            set_wb(1'b1, AW'(i), {$urandom, $urandom});
            cyc();
        end
        set_wb(1'b1, AW'(3), 64'h11); cyc();
        set_wb(1'b1, AW'(4), 64'h22); cyc();
        set_wb(1'b0, '0, '0);

        // Basic fetch.
        set_in(1'b1, AW'(3), AW'(4), 8'h5A, 1'b1, 1'b0); cyc();
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t1 out_valid", DW'(out_valid), DW'(1));
        chk("t1 rs1", out_rs1_data, 64'h11);
        chk("t1 rs2", out_rs2_data, 64'h22);
        chk("t1 tag", DW'(out_tag), DW'(8'h5A));
        cyc();

        // Accept-cycle write-back bypass.
        set_wb(1'b1, AW'(7), 64'h1234); cyc();
        set_in(1'b1, AW'(7), AW'(4), 8'h21, 1'b1, 1'b0);
        set_wb(1'b1, AW'(7), 64'hDEAD); cyc();
        set_wb(1'b0, '0, '0);
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t2 rs1 bypass", out_rs1_data, 64'hDEAD);

        // Stall with a write during the stall.
        set_in(1'b1, AW'(2), AW'(2), 8'h33, 1'b1, 1'b0); cyc();
        set_in(1'b1, AW'(9), AW'(9), 8'h99, 1'b0, 1'b0); #1;
        chk("t3 in_ready s1", DW'(in_ready), DW'(0));
        cyc();
        set_wb(1'b1, AW'(2), 64'hBEEF); #1;
        chk("t3 rs1 s2", out_rs1_data, 64'hBEEF);
        chk("t3 rs2 s2", out_rs2_data, 64'hBEEF);
        chk("t3 in_ready s2", DW'(in_ready), DW'(0));
        cyc();
        set_wb(1'b0, '0, '0); #1;
        chk("t3 rs1 s3", out_rs1_data, 64'hBEEF);
        chk("t3 rs2 s3", out_rs2_data, 64'hBEEF);
        chk("t3 in_ready s3", DW'(in_ready), DW'(0));
        chk("t3 tag s3", DW'(out_tag), DW'(8'h33));
        cyc();
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t3 rs1 release", out_rs1_data, 64'hBEEF);
        cyc();

        // Back-to-back throughput.
        set_in(1'b1, AW'(1), AW'(5), 8'd1, 1'b1, 1'b0); cyc();
        set_in(1'b1, AW'(6), AW'(8), 8'd2, 1'b1, 1'b0); #1;
        chk("t4 tag1", DW'(out_tag), DW'(1));
        chk("t4 in_ready1", DW'(in_ready), DW'(1));
        cyc();
        set_in(1'b1, AW'(10), AW'(11), 8'd3, 1'b1, 1'b0); #1;
        chk("t4 tag2", DW'(out_tag), DW'(2));
        chk("t4 in_ready2", DW'(in_ready), DW'(1));
        cyc();
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t4 tag3", DW'(out_tag), DW'(3));
        cyc();

        // Flush drops the held instruction and a same-cycle accept.
        set_in(1'b1, AW'(5), AW'(6), 8'h44, 1'b1, 1'b0); cyc();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0); cyc();
        set_in(1'b1, AW'(8), AW'(9), 8'h55, 1'b1, 1'b1); #1;
        chk("t5 held valid", DW'(out_valid), DW'(1));
        cyc();
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t5 flushed", DW'(out_valid), DW'(0));
        cyc();

        // Index 0 behaviour.
        set_in(1'b1, AW'(0), AW'(5), 8'h66, 1'b1, 1'b0);
        set_wb(1'b1, AW'(0), 64'hFF); #1;
        chk("t6 sram_we", DW'(sram_we), DW'(!ZERO_REG));
        cyc();
        set_wb(1'b0, '0, '0);
        set_in(1'b0, '0, '0, '0, 1'b1, 1'b0); #1;
        chk("t6 rs1 r0", out_rs1_data, ZERO_REG ? 64'h0 : 64'hFF);
        cyc();

        // Randomized traffic over a small register window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   TW'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            set_wb(($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), {$urandom, $urandom});
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
